// File: rtl/mux16_pkg.sv
// Shared types and constants for the 16-channel select scanner.
package mux16_pkg;

   localparam int unsigned N_CH  = 16;
   localparam int unsigned SEL_W = 4;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [N_CH-1:0]  chan_vec_t;

   typedef logic [1:0] scan_state_t;
   localparam scan_state_t IDLE  = 2'd0;
   localparam scan_state_t GRANT = 2'd1;
   localparam scan_state_t GAP   = 2'd2;

endpackage

// File: rtl/mux16_rr_pick.sv
// Combinational round-robin search: first set bit of vec at start, start+1, ... wrapping 15->0.
module mux16_rr_pick
   import mux16_pkg::*;
(
   input  chan_vec_t vec,
   input  sel_t      start,
   output sel_t      idx,
   output logic      found
);

   sel_t cand;

   // Walk from the farthest offset down so the nearest set bit is written last and wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         cand = start + sel_t'(i);
         if (vec[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux16_sel_scanner.sv
// Round-robin select generator for the 16:1 channel mux with valid/ready handshake and settle gap.
// Optional channel masking is compiled in with MUX16_SCAN_MASK_EN.
module mux16_sel_scanner
   import mux16_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned RESET_PTR  = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   input  chan_vec_t req,
`ifdef MUX16_SCAN_MASK_EN
   input  chan_vec_t chan_mask,
`endif
   input  logic      sel_ready,
   output sel_t      sel,
   output logic      sel_valid,
   output logic      busy
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   scan_state_t      state_q, state_d;
   sel_t             sel_q, sel_d;
   logic             valid_q, valid_d;
   sel_t             ptr_q, ptr_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   chan_vec_t eligible;
   sel_t      start;
   sel_t      pick_idx;
   logic      pick_found;
   logic      grant_ok;

`ifdef MUX16_SCAN_MASK_EN
   assign eligible = req & ~chan_mask;
`else
   assign eligible = req;
`endif

   // In GRANT the search must begin after the channel being acked, not at the stored pointer.
   assign start = (state_q == GRANT) ? sel_t'(sel_q + 1'b1) : ptr_q;

   mux16_rr_pick u_pick (
      .vec   (eligible),
      .start (start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign grant_ok = en && pick_found;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (grant_ok) begin
               state_d = GRANT;
               sel_d   = pick_idx;
               valid_d = 1'b1;
            end
         end
         GRANT: begin
            if (sel_ready) begin
               ptr_d = sel_q + 1'b1;
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  valid_d = 1'b0;
                  gap_d   = GAP_INIT;
               end else if (grant_ok) begin
                  sel_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               if (grant_ok) begin
                  state_d = GRANT;
                  sel_d   = pick_idx;
                  valid_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= sel_t'(RESET_PTR);
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux16_sel_scanner.sv
// Directed bench for mux16_sel_scanner: vector table on the default build plus short hand sequences.
module tb_mux16_sel_scanner;
   import mux16_pkg::*;

   logic      clk = 1'b0;
   logic      rst_a = 1'b1, rst_z = 1'b1, rst_g = 1'b1;
   logic      en = 1'b1;
   logic      ready = 1'b0;
   chan_vec_t req = '0;
   chan_vec_t mask = '0;

   sel_t sel_a, sel_z, sel_g;
   logic valid_a, valid_z, valid_g;
   logic busy_a, busy_z, busy_g;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mux16_sel_scanner u_dut (
      .clk       (clk),
      .rst       (rst_a),
      .en        (en),
      .req       (req),
`ifdef MUX16_SCAN_MASK_EN
      .chan_mask (mask),
`endif
      .sel_ready (ready),
      .sel       (sel_a),
      .sel_valid (valid_a),
      .busy      (busy_a)
   );

   mux16_sel_scanner #(.GAP_CYCLES(0), .RESET_PTR(0)) u_dut_nogap (
      .clk       (clk),
      .rst       (rst_z),
      .en        (en),
      .req       (req),
`ifdef MUX16_SCAN_MASK_EN
      .chan_mask (mask),
`endif
      .sel_ready (ready),
      .sel       (sel_z),
      .sel_valid (valid_z),
      .busy      (busy_z)
   );

   mux16_sel_scanner #(.GAP_CYCLES(3), .RESET_PTR(9)) u_dut_gap3 (
      .clk       (clk),
      .rst       (rst_g),
      .en        (en),
      .req       (req),
`ifdef MUX16_SCAN_MASK_EN
      .chan_mask (mask),
`endif
      .sel_ready (ready),
      .sel       (sel_g),
      .sel_valid (valid_g),
      .busy      (busy_g)
   );

   typedef struct {
      logic      rst;
      logic      en;
      logic      rdy;
      chan_vec_t req;
      sel_t      sel;
      logic      valid;
      logic      busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic e, logic y, chan_vec_t q, int s, logic v, logic b);
      vec_t t;
      t.rst = r; t.en = e; t.rdy = y; t.req = q; t.sel = sel_t'(s); t.valid = v; t.busy = b;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, sel_t s, logic v, logic b, sel_t es, logic ev, logic eb);
      total++;
      if (s === es && v === ev && b === eb) passed++;
      else $display("FAIL %s: got sel=%0d valid=%b busy=%b, want sel=%0d valid=%b busy=%b",
                    name, s, v, b, es, ev, eb);
   endtask

   initial begin
      // rst, en, rdy, req, exp sel, exp valid, exp busy (outputs after the edge)
      vecs.push_back(mk(1, 1, 1, 16'hFFFF,  0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 16'hFFFF,  0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h0020,  5, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0020,  5, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0020,  5, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0000,  5, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0000,  5, 0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h0000,  5, 0, 0));
      vecs.push_back(mk(1, 1, 1, 16'h0000,  0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h8001,  0, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001,  0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001, 15, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001, 15, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001,  0, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001,  0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001, 15, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h8001, 15, 0, 1));
      vecs.push_back(mk(0, 0, 1, 16'h8001, 15, 0, 0));
      vecs.push_back(mk(0, 0, 1, 16'h8001, 15, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h8001,  0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h8001,  0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h8001,  0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 16'h8001,  0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 16'h0000,  0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0008,  3, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0008,  3, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000,  3, 1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000,  3, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000,  3, 1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0000,  3, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0000,  3, 0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h0000,  3, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0100,  8, 1, 1));
      vecs.push_back(mk(1, 1, 0, 16'h0100,  0, 0, 0));
      // Pointer must be back at 0 after reset: bit 1 wins over bit 4.
      vecs.push_back(mk(0, 1, 0, 16'h0012,  1, 1, 1));

      #1;
      foreach (vecs[i]) begin
         rst_a = vecs[i].rst;
         en    = vecs[i].en;
         ready = vecs[i].rdy;
         req   = vecs[i].req;
         tick();
         check($sformatf("vec%0d", i), sel_a, valid_a, busy_a,
               vecs[i].sel, vecs[i].valid, vecs[i].busy);
      end
      rst_a = 1'b1;

      // Back-to-back grants with no settle gap.
      en = 1'b1; ready = 1'b1; req = 16'hFFFF;
      rst_z = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         check($sformatf("nogap%0d", k), sel_z, valid_z, busy_z, sel_t'((k - 1) % 16), 1'b1, 1'b1);
      end
      rst_z = 1'b1;

      // Three-cycle gap with non-zero reset pointer: 9, three idle cycles, then wrap to 0.
      req = 16'h0201;
      rst_g = 1'b0;
      begin
         int   es[6] = '{9, 9, 9, 9, 0, 0};
         logic ev[6] = '{1, 0, 0, 0, 1, 0};
         for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("gap3_%0d", k), sel_g, valid_g, busy_g, sel_t'(es[k]), ev[k], 1'b1);
         end
      end
      rst_g = 1'b1;

`ifdef MUX16_SCAN_MASK_EN
      tick();
      rst_a = 1'b1;
      tick();
      mask = 16'h00AA; req = 16'h00FF; ready = 1'b1; en = 1'b1;
      rst_a = 1'b0;
      begin
         int es[9] = '{0, 0, 2, 2, 4, 4, 6, 6, 0};
         for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("mask%0d", k), sel_a, valid_a, busy_a, sel_t'(es[k]),
                  (k % 2) == 0, 1'b1);
         end
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
